// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } ifu_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  function automatic logic [5:0] get_opcode(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; push and pop may coincide at any occupancy, including full.
module ifu_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch with credit-limited requests, response buffer and redirect flush.
// Optional IFU_PERF_CNT_EN adds a fetch_cnt output counting instructions handed to decode.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int unsigned        BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [5:0]        opcode,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt
`endif
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned EntW = ADDR_W + INSTR_W;

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;

  logic              req_hs, rsp_take, rsp_drop, instr_pop, credit_ok;
  logic [CntW-1:0]   tag_cnt, buf_cnt;
  logic              tag_full, tag_empty, buf_full, buf_empty;
  logic [ADDR_W-1:0] tag_pc;
  logic [EntW-1:0]   buf_rdata;

  // Outstanding requests are exactly the entries of the tag queue.
  ifu_fifo #(
    .Width (ADDR_W),
    .Depth (BUF_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect_valid),
    .push_i  (req_hs),
    .wdata_i (pc_q),
    .pop_i   (rsp_take),
    .rdata_o (tag_pc),
    .count_o (tag_cnt),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  ifu_fifo #(
    .Width (EntW),
    .Depth (BUF_DEPTH)
  ) u_buf_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect_valid),
    .push_i  (rsp_take),
    .wdata_i ({tag_pc, imem_rsp_data}),
    .pop_i   (instr_pop),
    .rdata_o (buf_rdata),
    .count_o (buf_cnt),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  assign credit_ok      = ({1'b0, tag_cnt} + {1'b0, buf_cnt}) < (CntW + 1)'(BUF_DEPTH);
  assign imem_req_valid = (state_q == RUN) && credit_ok && !tag_full && !buf_full;
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign rsp_take = imem_rsp_valid && (state_q == RUN) && !tag_empty;
  assign rsp_drop = imem_rsp_valid && (state_q == DRAIN) && (drop_cnt_q != '0);

  assign instr_valid = !buf_empty;
  assign instr_pop   = instr_valid && instr_ready;

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (!buf_empty) begin
      instr    = buf_rdata[INSTR_W-1:0];
      instr_pc = buf_rdata[EntW-1:INSTR_W];
    end
  end

  assign opcode = get_opcode(instr);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;

    unique case (state_q)
      IDLE:  state_d = RUN;
      RUN:   state_d = RUN;
      DRAIN: begin
        if (rsp_drop) drop_cnt_d = drop_cnt_q - CntW'(1);
        if (drop_cnt_d == '0) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (req_hs) pc_d = pc_q + ADDR_W'(4);

    // Everything still in flight after this cycle must be discarded on return.
    if (redirect_valid) begin
      pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
      drop_cnt_d = tag_cnt + drop_cnt_q + CntW'(req_hs) - CntW'(rsp_take || rsp_drop);
      state_d    = (drop_cnt_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (instr_pop) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_cnt_q <= '0;
    else        fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases push expected PCs, a monitor checks pops.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [5:0]  opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  instr_fetch_unit #(
    .ADDR_W    (32),
    .RESET_PC  (32'h0),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] log_q[$];
  logic [31:0] exp_q[$];
  int          lat = 1;
  int          budget = 0;
  int          cyc = 0;
  bit          sb_en = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    case (a[4:2])
      3'd0:    op = OP_ADDI;
      3'd1:    op = OP_RTYPE;
      3'd2:    op = OP_SLTI;
      3'd3:    op = OP_ANDI;
      3'd4:    op = OP_ORI;
      3'd5:    op = OP_XORI;
      default: op = 6'h23;
    endcase
    return {op, a[27:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: accepts while under budget, answers in order after lat cycles.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      pend_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_req_ready = 1'b0;
    end else begin
      pend_t p;
      cyc++;
      imem_rsp_valid = 1'b0;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(p.addr);
      end
      imem_req_ready = (log_q.size() < budget);
      if (imem_req_valid && imem_req_ready) begin
        p.addr = imem_req_addr;
        p.due  = cyc + lat;
        pend_q.push_back(p);
        log_q.push_back(imem_req_addr);
      end
    end
  end

  // Monitor: every decode handshake is matched against the head of the expected queue.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && sb_en && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_instr: got pc %h, expected no instruction", instr_pc);
      end else begin
        logic [31:0] e, w;
        e = exp_q.pop_front();
        w = mem_word(e);
        check("instr_pc", instr_pc, e);
        check("instr", instr, w);
        check("opcode", 32'(opcode), 32'(w[31:26]));
      end
    end
  end

  task automatic do_reset(input int l, input int b, input bit ir);
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = ir;
    lat            = l;
    budget         = b;
    sb_en          = 1'b0;
    exp_q.delete();
    log_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: got %0d undelivered, expected 0", name, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;

    // Reset values
    @(negedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_opcode", 32'(opcode), 32'd0);

    // 1: streaming, 1-cycle memory, decode always ready
    do_reset(1, 6, 1'b1);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    sb_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #2;
      check("p1_early_valid", 32'(instr_valid), 32'd0);
    end
    @(negedge clk);
    #2;
    check("p1_first_valid", 32'(instr_valid), 32'd1);
    check("p1_first_pc", instr_pc, 32'h0);
    wait_drain("p1", 100);
    check("p1_req_count", 32'(log_q.size()), 32'd6);
`ifdef IFU_PERF_CNT_EN
    check("p1_fetch_cnt", fetch_cnt, 32'd6);
`endif

    // 2: decode stalled for 10 cycles; credits cap requests at 2
    do_reset(1, 3, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    check("p2_hold_instr_a", instr, mem_word(32'h0));
    repeat (5) @(negedge clk);
    #2;
    check("p2_req_count", 32'(log_q.size()), 32'd2);
    check("p2_req_valid", 32'(imem_req_valid), 32'd0);
    check("p2_instr_valid", 32'(instr_valid), 32'd1);
    check("p2_hold_pc", instr_pc, 32'h0);
    check("p2_hold_instr_b", instr, mem_word(32'h0));
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    sb_en = 1'b1;
    @(negedge clk);
    instr_ready = 1'b1;
    wait_drain("p2", 100);

    // 3: 3-cycle memory, redirect with two requests in flight
    do_reset(3, 4, 1'b1);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    sb_en = 1'b1;
    repeat (3) @(negedge clk);
    do_redirect(32'h100);
    @(posedge clk);
    #1;
    check("p3_state", 32'(dut.state_q), 32'(DRAIN));
    check("p3_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    check("p3_flush_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    check("p3_drain_no_req", 32'(imem_req_valid), 32'd0);
    wait_drain("p3", 100);
    check("p3_req_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() >= 3) check("p3_new_addr", log_q[2], 32'h100);

    // 4: redirect coincides with a response and a request handshake
    do_reset(1, 4, 1'b1);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    sb_en = 1'b1;
    repeat (2) @(negedge clk);
    do_redirect(32'h203);
    @(posedge clk);
    #1;
    check("p4_state", 32'(dut.state_q), 32'(DRAIN));
    check("p4_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    check("p4_dropped_rsp", 32'(instr_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_drain("p4", 100);
    check("p4_req_count", 32'(log_q.size()), 32'd4);
    if (log_q.size() >= 3) check("p4_new_addr", log_q[2], 32'h200);

    // 5: PC wrap, then asynchronous reset mid-fetch
    do_reset(1, 0, 1'b1);
    do_redirect(32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    check("p5_redirect_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("p5_state", 32'(dut.state_q), 32'(RUN));
    @(negedge clk);
    redirect_valid = 1'b0;
    budget = 2;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    sb_en = 1'b1;
    wait_drain("p5", 100);
    if (log_q.size() >= 2) begin
      check("p5_addr_top", log_q[0], 32'hFFFF_FFFC);
      check("p5_addr_wrap", log_q[1], 32'h0);
    end
    sb_en  = 1'b0;
    budget = 1000;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("p5_async_req_valid", 32'(imem_req_valid), 32'd0);
    check("p5_async_req_addr", imem_req_addr, 32'h0);
    check("p5_async_instr_valid", 32'(instr_valid), 32'd0);
    check("p5_async_instr", instr, 32'h0);
    check("p5_async_instr_pc", instr_pc, 32'h0);
    check("p5_async_opcode", 32'(opcode), 32'd0);
    check("p5_async_pc", dut.pc_q, 32'h0);

`ifdef IFU_PERF_CNT_EN
    // 6: buffered entries flushed, then five pops counted
    do_reset(1, 2, 1'b0);
    repeat (8) @(negedge clk);
    do_redirect(32'h40);
    @(posedge clk);
    #1;
    check("p6_flushed", 32'(instr_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h40 + 32'(i * 4));
    sb_en       = 1'b1;
    budget      = 7;
    instr_ready = 1'b1;
    wait_drain("p6", 100);
    check("p6_fetch_cnt", fetch_cnt, 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
